// File: rtl/alu_rf_arbiter.sv
// Arbitrates the single-port operand register file between host (rd/wr) and ALU (rd-only, lockable).
// Optional build macro ALU_RF_ARB_PRIO_EN: fixed ALU priority instead of round-robin.
module alu_rf_arbiter #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  input  logic          a_req,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          rf_re,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_HOST = 2'd1,
    TAG_ALU  = 2'd2
  } tag_e;

  logic last_alu;
  logic locked;
  tag_e tag_q0;
  tag_e tag_q1;
  logic h_xfer;
  logic a_xfer;

  // Grant: lock pins the port to the ALU; contention resolved by round-robin or fixed ALU priority
  always_comb begin
    h_gnt = 1'b0;
    a_gnt = 1'b0;
    if (locked) begin
      a_gnt = a_req;
    end else if (h_req && a_req) begin
`ifdef ALU_RF_ARB_PRIO_EN
      a_gnt = 1'b1;
`else
      h_gnt = last_alu;
      a_gnt = !last_alu;
`endif
    end else begin
      h_gnt = h_req;
      a_gnt = a_req;
    end
  end

  assign h_xfer = h_req && h_gnt;
  assign a_xfer = a_req && a_gnt;

  // Ownership history and ALU lock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_alu <= 1'b1;
      locked   <= 1'b0;
    end else begin
      if (h_xfer) begin
        last_alu <= 1'b0;
      end else if (a_xfer) begin
        last_alu <= 1'b1;
      end
      if (!a_lock) begin
        locked <= 1'b0;
      end else if (a_xfer) begin
        locked <= 1'b1;
      end
    end
  end

  // Issue stage: drive the RF with the winner's access; the owner tag travels alongside rf_re
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_re    <= 1'b0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      tag_q0   <= TAG_NONE;
    end else begin
      rf_re  <= (h_xfer && !h_we) || a_xfer;
      rf_we  <= h_xfer && h_we;
      tag_q0 <= TAG_NONE;
      if (h_xfer) begin
        rf_addr <= h_addr;
        if (h_we) begin
          rf_wdata <= h_wdata;
        end else begin
          tag_q0 <= TAG_HOST;
        end
      end else if (a_xfer) begin
        rf_addr <= a_addr;
        tag_q0  <= TAG_ALU;
      end
    end
  end

  // Return stage: route RF read data to the owner two edges after transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q1   <= TAG_NONE;
      h_rvalid <= 1'b0;
      a_rvalid <= 1'b0;
      h_rdata  <= '0;
      a_rdata  <= '0;
    end else begin
      tag_q1   <= tag_q0;
      h_rvalid <= (tag_q1 == TAG_HOST);
      a_rvalid <= (tag_q1 == TAG_ALU);
      if (tag_q1 == TAG_HOST) begin
        h_rdata <= rf_rdata;
      end
      if (tag_q1 == TAG_ALU) begin
        a_rdata <= rf_rdata;
      end
    end
  end

  assign busy = rf_re || rf_we || (tag_q0 != TAG_NONE) || (tag_q1 != TAG_NONE);

endmodule

// File: doc/alu_rf_arbiter.md
Name: alu_rf_arbiter

Overview:
Shares the single-port operand register file between two requesters: the host/bus side (read and write) and the ALU sequencer (read-only operand fetch).
- Round-robin arbitration, one access per cycle, back-to-back accesses allowed.
- ALU lock lets operand1/operand2 fetches complete without host interleaving.
- Read data is returned to the owning requester with fixed 2-cycle latency.

Parameters:
AW, 4, register-file address width
DW, 32, data width

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
h_req  in  1  host access request
h_we  in  1  host write (1) / read (0)
h_addr  in  AW  host address
h_wdata  in  DW  host write data
h_gnt  out  1  host accepted this cycle (combinational)
h_rvalid  out  1  host read data valid, 1-cycle pulse
h_rdata  out  DW  host read data
a_req  in  1  ALU read request
a_lock  in  1  ALU holds the port after its grant
a_addr  in  AW  ALU read address
a_gnt  out  1  ALU accepted this cycle (combinational)
a_rvalid  out  1  ALU read data valid, 1-cycle pulse
a_rdata  out  DW  ALU read data
rf_re  out  1  register-file read enable
rf_we  out  1  register-file write enable
rf_addr  out  AW  register-file address
rf_wdata  out  DW  register-file write data
rf_rdata  in  DW  register-file read data, valid the cycle after rf_re
busy  out  1  access in flight (rf_re, rf_we, or pipeline stage occupied)

Behaviour:
- Reset values: all registered outputs 0. Internal state after reset: last_owner = ALU, locked = 0, owner pipeline empty.
- Reset mid-operation: in-flight reads are discarded; no rvalid is issued after reset release.
- Handshake:
  - Requester holds req and its fields stable until it sees gnt.
  - Transfer happens on the rising edge where req && gnt.
  - At most one of h_gnt/a_gnt is high in any cycle.
  - A req still high after the grant edge is a new request.
- Grant logic (combinational from req and registered state):
  - locked=1: a_gnt = a_req; h_gnt = 0.
  - Single requester: that requester is granted.
  - Both requesting: grant the one that is not last_owner.
  - last_owner updates on every transfer.
- Lock:
  - locked <= 1 on an ALU transfer with a_lock=1.
  - locked <= 0 on any edge where a_lock=0.
  - a_lock without a prior ALU grant has no effect.
- Issue stage (edge after transfer):
  - rf_addr/rf_wdata take the winner's fields.
  - rf_re = 1 for reads; rf_we = 1 for host writes.
  - rf_re/rf_we return to 0 the following cycle if there is no new transfer.
  - rf_wdata holds its last value when idle.
- Return stage:
  - Owner tag (none/host/ALU) is shifted through two registers alongside rf_re.
  - Edge E0 = transfer, E1 = RF read, E2 = rdata captured into the owner's x_rdata with x_rvalid=1 for one cycle.
  - Writes produce no rvalid.
  - x_rdata holds its value until that requester's next read.
- Back-to-back: reads issued on consecutive edges return on consecutive edges, in issue order.
- Ordering: accesses reach the RF strictly in transfer order. A host write to R followed next cycle by an ALU read of R returns the new value.
- busy = rf_re | rf_we | any occupied pipeline tag.

Optional Feature:
ALU_RF_ARB_PRIO_EN
- Defined: fixed priority to the ALU. When both request, the ALU always wins and last_owner is ignored; the host may starve while a_req stays high.
- Undefined: round-robin as above.
- Lock behaviour is identical in both builds.

Test Plan:
1. Reset, then host writes R3=32'hDEAD_BEEF; two cycles later ALU reads R3 -> a_gnt same cycle as a_req, a_rvalid 2 cycles after transfer, a_rdata=32'hDEAD_BEEF, h_rvalid stays 0.
2. h_req and a_req both held high with reads for 4 cycles right after reset -> grants H,A,H,A; rvalids alternate with 2-cycle latency.
3. ALU reads R1 with a_lock=1, then R2; host requests throughout -> h_gnt=0 until a_lock drops; host granted the cycle after a_lock=0.
4. ALU issues 3 back-to-back reads R4,R5,R6 (preloaded 4,5,6) -> a_rvalid high 3 consecutive cycles, a_rdata 4,5,6 in order.
5. reset_n asserted the cycle after an ALU read transfer -> all outputs 0 asynchronously; no a_rvalid after release; busy=0.
6. Build with ALU_RF_ARB_PRIO_EN, both requesting for 3 cycles -> a_gnt all 3 cycles, h_gnt 0; host granted the first cycle a_req=0.
